// File: rtl/muskbus_write_arbiter.sv
`default_nettype none
// ============================================================================
// muskbus_write_arbiter: round-robin arbiter sharing one cache-line writer
// among N clients, with a sticky writer-timeout flag.      Revision: 1.0
// ============================================================================
module muskbus_write_arbiter #(
   parameter int N       = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           req_reqcyc,
   input  logic [N*64-1:0]        req_addr,
   input  logic [0:N*512-1]       req_data,
   output logic [N-1:0]           req_respcyc,
   output logic                   wr_reqcyc,
   output logic [63:0]            wr_addr,
   output logic [0:511]           wr_data,
   input  logic                   wr_respcyc,
   output logic                   busy,
   output logic [$clog2(N)-1:0]   grant_id,
   output logic                   err
);

   localparam int c_GW = $clog2(N);
   localparam int c_CW = $clog2(TIMEOUT) + 1;
   localparam logic [c_GW-1:0] c_LAST_CLIENT = c_GW'(N - 1);
   localparam logic [c_CW-1:0] c_TMO_LIMIT   = c_CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [c_GW-1:0]   grant_q, grant_d;
   logic [c_GW-1:0]   last_q, last_d;
   logic [63:0]       addr_q, addr_d;
   logic [0:511]      data_q, data_d;
   logic [c_CW-1:0]   tmo_q, tmo_d;
   logic              err_q, err_d;

   logic              found;
   logic [c_GW-1:0]   winner;
   logic [c_GW-1:0]   ptr;

   // Walk the clients once, starting just after the last grant and wrapping.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      ptr    = last_q;
      for (int k = 0; k < N; k++) begin
         ptr = (ptr == c_LAST_CLIENT) ? '0 : ptr + c_GW'(1);
         if (!found && req_reqcyc[ptr]) begin
            found  = 1'b1;
            winner = ptr;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      addr_d      = addr_q;
      data_d      = data_q;
      tmo_d       = tmo_q;
      err_d       = err_q;
      wr_reqcyc   = 1'b0;
      req_respcyc = '0;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = winner;
               addr_d  = req_addr[int'(winner)*64 +: 64];
               data_d  = req_data[int'(winner)*512 +: 512];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            wr_reqcyc = 1'b1;
            tmo_d     = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            // A completion in the limit cycle still counts as a good transfer.
            if (wr_respcyc) begin
               state_d = DONE;
            end else if (tmo_q == c_TMO_LIMIT) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else if (tmo_q != '1) begin
               tmo_d = tmo_q + c_CW'(1);
            end
         end
         DONE: begin
            req_respcyc[grant_q] = 1'b1;
            last_d               = grant_q;
            state_d              = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= c_LAST_CLIENT;
         addr_q  <= '0;
         data_q  <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign grant_id = grant_q;
   assign wr_addr  = addr_q;
   assign wr_data  = data_q;
   assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_muskbus_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_muskbus_write_arbiter: randomized scoreboard bench for the write arbiter.
// Revision: 1.0
// ============================================================================
module tb_muskbus_write_arbiter;

   localparam int N       = 4;
   localparam int TIMEOUT = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic [N-1:0]       req_reqcyc;
   logic [N*64-1:0]    req_addr;
   logic [0:N*512-1]   req_data;
   logic [N-1:0]       req_respcyc;
   logic               wr_reqcyc;
   logic [63:0]        wr_addr;
   logic [0:511]       wr_data;
   logic               wr_respcyc;
   logic               busy;
   logic [1:0]         grant_id;
   logic               err;

   muskbus_write_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_reqcyc  (req_reqcyc),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_respcyc (req_respcyc),
      .wr_reqcyc   (wr_reqcyc),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_respcyc  (wr_respcyc),
      .busy        (busy),
      .grant_id    (grant_id),
      .err         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int           id;
      logic [63:0]  addr;
      logic [0:511] data;
   } gexp_t;

   typedef struct {
      int   lat;
      logic err;
   } wexp_t;

   gexp_t        gq[$];
   wexp_t        wq[$];
   int           n_vec = 0;
   int           n_err = 0;
   logic [63:0]  caddr [N];
   logic [0:511] cdata [N];
   logic [N-1:0] rereq, pend;
   int           wcnt, wforce, last_m;
   logic         err_m;
   int           cyc;
   bit           inflight, chk_idle;
   gexp_t        cur;
   int           issue_cyc;

   function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [0:511] rand_line();
      logic [0:511] v;
      for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic void drive_bus();
      for (int i = 0; i < N; i++) begin
         req_addr[i*64 +: 64]   = caddr[i];
         req_data[i*512 +: 512] = cdata[i];
      end
   endfunction

   function automatic void fill(logic [N-1:0] mask);
      for (int i = 0; i < N; i++)
         if (mask[i]) begin
            caddr[i] = {$urandom, $urandom};
            cdata[i] = rand_line();
         end
      drive_bus();
   endfunction

   // One cycle of client and writer behaviour, acting on the falling edge.
   task automatic tick();
      int d;
      @(negedge clk);
      req_reqcyc = req_reqcyc | pend;
      pend       = '0;
      for (int i = 0; i < N; i++)
         if (req_respcyc[i]) begin
            req_reqcyc[i] = 1'b0;
            if (rereq[i]) begin
               rereq[i] = 1'b0;
               pend[i]  = 1'b1;
            end
         end
      wr_respcyc = 1'b0;
      if (wr_reqcyc) begin
         d = (wforce != 0) ? wforce : int'($urandom_range(1, TIMEOUT + 4));
         if (d > TIMEOUT) begin
            err_m = 1'b1;
            wcnt  = 0;
            wq.push_back('{TIMEOUT + 1, 1'b1});
         end else begin
            wcnt = d;
            wq.push_back('{d + 1, err_m});
         end
      end else if (wcnt > 0) begin
         wcnt--;
         if (wcnt == 0) wr_respcyc = 1'b1;
      end
   endtask

   // Reference: serve the pending set in circular order after the last grant;
   // a re-requesting client rejoins the set once after its first service.
   task automatic batch_start(logic [N-1:0] mask, logic [N-1:0] rr);
      logic [N-1:0] pending;
      logic [N-1:0] again;
      pending = mask;
      again   = rr;
      while (pending != '0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (last_m + k) % N;
            if (pending[c]) begin
               gq.push_back('{c, caddr[c], cdata[c]});
               pending[c] = 1'b0;
               if (again[c]) begin
                  again[c]   = 1'b0;
                  pending[c] = 1'b1;
               end
               last_m = c;
               break;
            end
         end
      end
      rereq      = rr;
      req_reqcyc = req_reqcyc | mask;
   endtask

   task automatic wait_idle(int budget);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((req_reqcyc != '0 || pend != '0 || busy || wcnt != 0) && n < budget);
      if (n >= budget) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_wait: got busy after %0d cycles, expected idle", n);
      end
   endtask

   task automatic batch(logic [N-1:0] mask, logic [N-1:0] rr);
      batch_start(mask, rr);
      wait_idle(1000);
   endtask

   initial begin : monitor
      wexp_t        w;
      logic [N-1:0] one;
      cyc      = 0;
      inflight = 0;
      chk_idle = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (chk_idle) begin
            chk_idle = 0;
            chk("busy_after_done", busy, 0);
         end
         if (wr_reqcyc) begin
            chk("double_issue", inflight, 0);
            if (gq.size() == 0) begin
               chk("unexpected_issue", wr_reqcyc, 0);
            end else begin
               cur = gq.pop_front();
               chk("grant_id", grant_id, cur.id);
               chk("wr_addr", wr_addr, cur.addr);
               chk("wr_data", wr_data, cur.data);
               inflight  = 1;
               issue_cyc = cyc;
            end
         end
         if (req_respcyc != '0) begin
            if (!inflight || wq.size() == 0) begin
               chk("unexpected_resp", req_respcyc, 0);
            end else begin
               w      = wq.pop_front();
               one    = '0;
               one[cur.id] = 1'b1;
               chk("req_respcyc", req_respcyc, one);
               chk("done_latency", cyc - issue_cyc, w.lat);
               chk("err", err, w.err);
               chk("wr_addr_hold", wr_addr, cur.addr);
               chk("wr_data_hold", wr_data, cur.data);
               inflight = 0;
               chk_idle = 1;
            end
         end
      end
   end

   initial begin : stimulus
      logic [N-1:0] m;
      reset      = 1'b1;
      req_reqcyc = '0;
      wr_respcyc = 1'b0;
      pend       = '0;
      rereq      = '0;
      wcnt       = 0;
      wforce     = 0;
      err_m      = 1'b0;
      last_m     = N - 1;
      for (int i = 0; i < N; i++) begin
         caddr[i] = '0;
         cdata[i] = '0;
      end
      drive_bus();
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_wr_reqcyc", wr_reqcyc, 0);
      chk("rst_respcyc", req_respcyc, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_err", err, 0);
      reset = 1'b0;

      // All four requesting, clients 0 and 1 re-request: 0,1,2,3,0,1
      fill('1);
      batch(4'b1111, 4'b0011);

      // Single client, writer answers 10 cycles into WAIT
      caddr[2] = 64'h1000;
      for (int j = 0; j < 64; j++) cdata[2][j*8 +: 8] = 8'(j);
      drive_bus();
      wforce = 10;
      batch(4'b0100, '0);
      chk("single_err", err, 0);

      // Re-request fairness: 1,3,1
      wforce = 0;
      fill('1);
      batch(4'b0001, '0);
      batch(4'b1010, 4'b0010);

      // Completion exactly in the limit cycle beats the timeout
      wforce = TIMEOUT;
      batch(4'b1000, '0);
      chk("limit_err", err, 0);

      // Writer never answers, then later good transfers keep err
      wforce = 100;
      batch(4'b0001, '0);
      wforce = 3;
      batch(4'b0110, '0);
      chk("sticky_err", err, 1);

      // Interference during WAIT: others toggle, all inputs scrambled
      wforce = 8;
      fill(4'b0001);
      batch_start(4'b0001, '0);
      tick();
      tick();
      tick();
      fill('1);
      req_reqcyc = 4'b1110;
      tick();
      req_reqcyc = '0;
      wait_idle(1000);

      // Stray writer completion while idle
      wr_respcyc = 1'b1;
      tick();
      tick();
      tick();
      chk("stray_busy", busy, 0);
      chk("stray_resp", req_respcyc, 0);

      // Reset in WAIT drops the transfer; client 0 then wins first
      wforce = 0;
      batch(4'b0010, '0);
      wforce = 100;
      fill(4'b0100);
      batch_start(4'b0100, '0);
      tick();
      tick();
      tick();
      reset      = 1'b1;
      gq.delete();
      wq.delete();
      inflight   = 0;
      req_reqcyc = '0;
      pend       = '0;
      rereq      = '0;
      wcnt       = 0;
      err_m      = 1'b0;
      last_m     = N - 1;
      wforce     = 0;
      tick();
      reset = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_resp", req_respcyc, 0);
      chk("mid_rst_wr_reqcyc", wr_reqcyc, 0);
      chk("mid_rst_grant", grant_id, 0);
      chk("mid_rst_wr_addr", wr_addr, 0);
      chk("mid_rst_err", err, 0);
      fill('1);
      batch(4'b0101, '0);

      // Randomized batches with random writer delays and occasional timeouts
      for (int t = 0; t < 25; t++) begin
         m = N'($urandom_range(1, (1 << N) - 1));
         fill(m);
         batch(m, m & N'($urandom));
      end

      chk("grant_queue_drained", gq.size(), 0);
      chk("writer_queue_drained", wq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
